mul_div_unit: RTL and testbench

Iterative multiply/divide execution unit for the RISC-V pipeline's EX stage. It accepts an operation when the ID stage decodes an RV32M instruction (`activate_mul_module` high) and the pipeline presents the operands. It holds the pipeline through `stall` while it computes, then returns a registered 32-bit result with a one-cycle `done` pulse. The decoder emits the multiply-active flag and ALU code; this block consumes them.

---
 rtl/mul_div_unit.sv | 145 ++++++++++++++
 tb/tb_mul_div_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, with single-cycle fast paths.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [3:0] OP_MUL  = 4'b0000;
  localparam logic [3:0] OP_MULH = 4'b0001;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_REM  = 4'b0110;

  localparam logic [5:0]      LAST_COUNT = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT    = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t            state, state_next;
  logic [3:0]        op_q;
  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag;          // multiplicand for MUL*, divisor for DIV/REM
  logic [2*XLEN-1:0] acc;          // {hi, multiplier} or {remainder, quotient}
  logic [5:0]        count;

  logic              is_mul_op, is_div_op, div_zero, div_ovf, fast, accept;
  logic [XLEN-1:0]   abs_a, abs_b, fast_result, final_result;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_next, product;

  assign is_mul_op = (op == OP_MUL) || (op == OP_MULH);
  assign is_div_op = (op == OP_DIV) || (op == OP_REM);
  assign div_zero  = (operand_b == '0);
  assign div_ovf   = (operand_a == MIN_INT) && (operand_b == '1);
  assign fast      = is_div_op ? (div_zero || div_ovf) : !is_mul_op;
  assign abs_a     = operand_a[XLEN-1] ? -operand_a : operand_a;
  assign abs_b     = operand_b[XLEN-1] ? -operand_b : operand_b;

  assign busy   = (state == MUL) || (state == DIV);
  assign done   = (state == DONE);
  assign accept = start && ((state == IDLE) || (state == DONE)) && !flush;
  assign stall  = accept || busy;

  // One iteration of each algorithm; only the one matching the state is used.
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag} : '0);
  assign div_shift = acc[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, mag};

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    acc_next     = acc;
    product      = '0;
    final_result = '0;
    fast_result  = '0;

    if (state == MUL) begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end else if (div_diff[XLEN]) begin
      acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    product = (sign_a ^ sign_b) ? -acc_next : acc_next;
    case (op_q)
      OP_MUL:  final_result = product[XLEN-1:0];
      OP_MULH: final_result = product[2*XLEN-1:XLEN];
      OP_DIV:  final_result = (sign_a ^ sign_b) ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      OP_REM:  final_result = sign_a ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
      default: final_result = '0;
    endcase

    if (is_div_op && div_zero) begin
      fast_result = (op == OP_DIV) ? '1 : operand_a;
    end else if (is_div_op && div_ovf) begin
      fast_result = (op == OP_DIV) ? MIN_INT : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          if (fast)           state_next = DONE;
          else if (is_mul_op) state_next = MUL;
          else                state_next = DIV;
        end else begin
          state_next = IDLE;
        end
      end
      MUL, DIV: begin
        if (flush)                    state_next = IDLE;
        else if (count == LAST_COUNT) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, so nothing X can leak into result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag    <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state <= state_next;
      if (accept) begin
        op_q   <= op;
        sign_a <= operand_a[XLEN-1];
        sign_b <= operand_b[XLEN-1];
        count  <= '0;
        if (is_mul_op) begin
          mag <= abs_a;
          acc <= {{XLEN{1'b0}}, abs_b};
        end else begin
          mag <= abs_b;
          acc <= {{XLEN{1'b0}}, abs_a};
        end
        if (fast) result <= fast_result;
      end else if (busy && !flush) begin
        acc <= acc_next;
        if (count == LAST_COUNT) result <= final_result;
        else                     count  <= count + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a queue scoreboard checks every done result,
// and the sequence checks stall/busy/done timing, fast paths, flush and reset.
module tb_mul_div_unit;

  localparam logic [3:0] OP_MUL  = 4'b0000;
  localparam logic [3:0] OP_MULH = 4'b0001;
  localparam logic [3:0] OP_DIV  = 4'b0100;
  localparam logic [3:0] OP_REM  = 4'b0110;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [3:0]  op;
  logic [31:0] operand_a, operand_b;
  logic        stall, busy, done;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_result = 32'h0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      check_bit("done_has_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("result", result, exp_q.pop_front());
    end
  end

  // Called just after a rising edge; drives a one-cycle start request.
  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      last_result = exp;
    end
  endtask

  // Start cycle plus 32 iteration cycles; optionally re-asserts start at T+disturb.
  task automatic iter_body(input int disturb, input bit prev_done);
    @(negedge clk);
    check_bit("stall_start_cycle", stall, 1'b1);
    if (prev_done) check_bit("chain_prev_done", done, 1'b1);
    @(posedge clk); #1 start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      if (k == disturb) begin
        op = OP_DIV; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
      end
      @(negedge clk);
      check_bit("busy_iter", busy, 1'b1);
      check_bit("stall_iter", stall, 1'b1);
      check_bit("no_done_iter", done, 1'b0);
      @(posedge clk); #1 start = 1'b0;
    end
  endtask

  task automatic finish_done();
    @(negedge clk);
    check_bit("done_pulse", done, 1'b1);
    check_bit("busy_in_done", busy, 1'b0);
    check_bit("stall_in_done", stall, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic run_iter(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
    issue(o, a, b, exp, 1'b1);
    iter_body(0, 1'b0);
    finish_done();
  endtask

  task automatic fast_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    issue(o, a, b, exp, 1'b1);
    @(negedge clk);
    check_bit("fast_stall_start", stall, 1'b1);
    check_bit("fast_busy_start", busy, 1'b0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_bit("fast_done", done, 1'b1);
    check_bit("fast_busy", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    op = 4'h0; operand_a = 32'h0; operand_b = 32'h0;
    #12;
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_stall", stall, 1'b0);
    check("rst_result", result, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Iterative multiplies and divides
    run_iter(OP_MUL,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    run_iter(OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
    run_iter(OP_MUL,  32'h80000000, 32'h80000000, 32'h00000000);
    run_iter(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
    run_iter(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    run_iter(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_iter(OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_iter(OP_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001);
    run_iter(OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14);
    run_iter(OP_REM,  32'd100,      32'd7,        32'd2);

    // Fast paths
    fast_op(OP_DIV, 32'd5,        32'd0,        32'hFFFFFFFF);
    fast_op(OP_REM, 32'd5,        32'd0,        32'h00000005);
    fast_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    fast_op(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
    fast_op(4'b0010, 32'd9,       32'd3,        32'h00000000);

    // start together with flush in IDLE is ignored
    op = OP_MUL; operand_a = 32'd2; operand_b = 32'd3; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check_bit("flush_start_stall", stall, 1'b0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_bit("flush_start_busy", busy, 1'b0);
    check_bit("flush_start_done", done, 1'b0);
    @(posedge clk); #1;

    // start re-asserted mid-operation is ignored
    issue(OP_MUL, 32'h00012345, 32'hFFFFFF00, 32'hFEDCBB00, 1'b1);
    iter_body(5, 1'b0);
    finish_done();

    // flush at T+10 aborts without done and keeps result
    issue(OP_MUL, 32'd5, 32'd6, 32'd30, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    check_bit("flush_busy_before", busy, 1'b1);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check_bit("flush_busy_after", busy, 1'b0);
    check_bit("flush_stall_after", stall, 1'b0);
    check_bit("flush_no_done", done, 1'b0);
    check("flush_result_held", result, last_result);
    repeat (35) @(posedge clk);
    #1 check("flush_result_later", result, last_result);

    // reset low at T+20 clears everything immediately
    issue(OP_DIV, 32'd1000, 32'd3, 32'd333, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    check_bit("pre_reset_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check_bit("midrst_busy", busy, 1'b0);
    check_bit("midrst_stall", stall, 1'b0);
    check_bit("midrst_done", done, 1'b0);
    check("midrst_result", result, 32'h0);
    last_result = 32'h0;
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("post_reset_result", result, 32'h0);

    // back-to-back: second op starts in the first one's DONE cycle
    issue(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b1);
    iter_body(0, 1'b0);
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b1);
    iter_body(0, 1'b1);
    finish_done();

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
